// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the VGA draw sequencer.
// Optional feature macro: DRAW_SEQ_CLEAR_OLD_EN (erase old pointer before redraw).
package vga_draw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_LOW,
        WAIT_DONE
    } state_t;

    localparam logic [2:0] COL_P0    = 3'b100;
    localparam logic [2:0] COL_P1    = 3'b110;
    localparam logic [2:0] COL_PTR   = 3'b111;
    localparam logic [2:0] COL_ERASE = 3'b000;

    localparam int CELL_PITCH = 8;
    localparam int MAX_COL    = 6;
    localparam int MAX_ROW    = 5;

    typedef struct packed {
        logic       kind;
        logic       player;
        logic [2:0] col;
        logic [2:0] row;
    } req_t;

    function automatic logic [7:0] cell_x(input logic [7:0] org,
                                          input logic [2:0] c);
        return org + 8'(c) * 8'(CELL_PITCH);
    endfunction

    function automatic logic [6:0] cell_y(input logic [6:0] org,
                                          input logic [2:0] r);
        return org + 7'(r) * 7'(CELL_PITCH);
    endfunction

endpackage

// File: rtl/draw_req_fifo.sv
// Synchronous request FIFO with show-ahead read data.
// Push while full is ignored; push and pop may coincide.
module draw_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/draw_sequencer_vga.sv
// Queues game draw requests and sequences them into the sprite draw engine.
// Optional feature macro: DRAW_SEQ_CLEAR_OLD_EN (erase old pointer before redraw).
module draw_sequencer_vga
    import vga_draw_pkg::*;
#(
    parameter logic [7:0] X_ORIGIN   = 8'd20,
    parameter logic [6:0] Y_ORIGIN   = 7'd30,
    parameter logic [6:0] POINTER_Y  = 7'd20,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_kind,
    input  logic       req_player,
    input  logic [2:0] req_col,
    input  logic [2:0] req_row,
    output logic       go,
    output logic       is_player,
    output logic [7:0] x_base,
    output logic [6:0] y_base,
    output logic [2:0] colour,
    input  logic       done,
    output logic       busy,
    output logic       err
);
    state_t state;
    req_t   in_req;
    req_t   fifo_rdata;
    req_t   cur;
    logic   fifo_full;
    logic   fifo_empty;
    logic   accept;
    logic   bad;
    logic   pop;
    logic [7:0] nx_x;
    logic [6:0] nx_y;
    logic [2:0] nx_c;

`ifdef DRAW_SEQ_CLEAR_OLD_EN
    logic [2:0] last_col;
    logic       pending;
    req_t       held;
    logic       need_erase;
`endif

    assign in_req    = {req_kind, req_player, req_col, req_row};
    assign req_ready = !fifo_full;
    assign accept    = req_valid && req_ready;
    assign bad       = (req_col > 3'(MAX_COL))
                    || (req_kind && (req_row > 3'(MAX_ROW)));
    assign busy      = (state != IDLE);

`ifdef DRAW_SEQ_CLEAR_OLD_EN
    assign pop = (state == LOAD) && !pending;
`else
    assign pop = (state == LOAD);
`endif

    draw_req_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (resetn),
        .push  (accept && !bad),
        .wdata (in_req),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The held entry replays the pointer after its erase without a pop.
    always_comb begin
        cur = fifo_rdata;
`ifdef DRAW_SEQ_CLEAR_OLD_EN
        if (pending) cur = held;
        need_erase = !pending && !cur.kind && (cur.col != last_col);
`endif
        nx_x = cell_x(X_ORIGIN, cur.col);
        nx_y = cur.kind ? cell_y(Y_ORIGIN, cur.row) : POINTER_Y;
        nx_c = !cur.kind ? COL_PTR : (cur.player ? COL_P1 : COL_P0);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state     <= IDLE;
            go        <= 1'b0;
            err       <= 1'b0;
            x_base    <= '0;
            y_base    <= '0;
            colour    <= '0;
            is_player <= 1'b0;
`ifdef DRAW_SEQ_CLEAR_OLD_EN
            last_col  <= '0;
            pending   <= 1'b0;
            held      <= '0;
`endif
        end else begin
            err <= accept && bad;
            go  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    state <= ISSUE;
                    go    <= 1'b1;
`ifdef DRAW_SEQ_CLEAR_OLD_EN
                    if (need_erase) begin
                        x_base    <= cell_x(X_ORIGIN, last_col);
                        y_base    <= POINTER_Y;
                        colour    <= COL_ERASE;
                        is_player <= 1'b0;
                        pending   <= 1'b1;
                        held      <= cur;
                    end else begin
                        x_base    <= nx_x;
                        y_base    <= nx_y;
                        colour    <= nx_c;
                        is_player <= cur.kind;
                        pending   <= 1'b0;
                        if (!cur.kind) last_col <= cur.col;
                    end
`else
                    x_base    <= nx_x;
                    y_base    <= nx_y;
                    colour    <= nx_c;
                    is_player <= cur.kind;
`endif
                end
                ISSUE: begin
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!done) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
`ifdef DRAW_SEQ_CLEAR_OLD_EN
                    if (done) state <= pending ? LOAD : IDLE;
`else
                    if (done) state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_sequencer_vga.sv
// Scoreboard bench for draw_sequencer_vga with a behavioural draw model.
// Honours DRAW_SEQ_CLEAR_OLD_EN when the design is built with it.
module tb_draw_sequencer_vga;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_kind = 1'b0;
    logic       req_player = 1'b0;
    logic [2:0] req_col = '0;
    logic [2:0] req_row = '0;
    logic       done = 1'b1;
    logic       req_ready, go, is_player, busy, err;
    logic [7:0] x_base;
    logic [6:0] y_base;
    logic [2:0] colour;

    logic hold = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   gos = 0;
    int   model_last = 0;

    typedef struct packed {
        logic       isp;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } draw_t;

    draw_t sb[$];

    draw_sequencer_vga dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_player (req_player),
        .req_col    (req_col),
        .req_row    (req_row),
        .go         (go),
        .is_player  (is_player),
        .x_base     (x_base),
        .y_base     (y_base),
        .colour     (colour),
        .done       (done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic draw_t mk(input int isp, input int x,
                                 input int y, input int c);
        draw_t d;
        d.isp = isp[0];
        d.x   = x[7:0];
        d.y   = y[6:0];
        d.c   = c[2:0];
        return d;
    endfunction

    // Board geometry: origin (20,30), pitch 8, pointer row at y=20.
    task automatic model_push(input int k, input int p,
                              input int c, input int r);
        if (k != 0) begin
            sb.push_back(mk(1, 20 + c * 8, 30 + r * 8, p != 0 ? 6 : 4));
        end else begin
`ifdef DRAW_SEQ_CLEAR_OLD_EN
            if (c != model_last) sb.push_back(mk(0, 20 + model_last * 8, 20, 0));
`endif
            model_last = c;
            sb.push_back(mk(0, 20 + c * 8, 20, 7));
        end
    endtask

    initial begin
        draw_t e;
        forever begin
            @(negedge clk);
            if (go === 1'b1) begin
                gos++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_go: x=%0d y=%0d c=%0b",
                             x_base, y_base, colour);
                end else begin
                    e = sb.pop_front();
                    check("draw", 32'({is_player, x_base, y_base, colour}),
                          32'(e));
                end
                check("busy_on_go", 32'(busy), 32'd1);
                @(negedge clk);
                check("go_width", 32'(go), 32'd0);
            end
        end
    end

    // Draw engine: done is a level that drops on go and rises later.
    initial begin
        forever begin
            @(negedge clk);
            if (go && !hold) begin
                done = 1'b0;
                repeat ($urandom_range(2, 5)) @(posedge clk);
                #1 done = 1'b1;
            end
        end
    end

    task automatic send(input int k, input int p, input int c, input int r);
        int  n;
        logic bad;
        n = 0;
        req_valid  = 1'b1;
        req_kind   = k[0];
        req_player = p[0];
        req_col    = c[2:0];
        req_row    = r[2:0];
        while (!req_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready=%0b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        bad = (c > 6) || (k != 0 && r > 5);
        if (!bad) model_push(k, p, c, r);
        check("err", 32'(err), 32'(bad));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("idle_reached", 32'(busy || sb.size() != 0), 32'd0);
    endtask

    initial begin
        int cnt;
        logic acc, last_acc;
        int g0, n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_go", 32'(go), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out", 32'({is_player, x_base, y_base, colour}), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(1, 1, 3, 2);
        check("lat_n1", 32'(go), 32'd0);
        @(posedge clk);
        #1;
        check("lat_n2", 32'(go), 32'd0);
        @(posedge clk);
        #1;
        check("lat_n3", 32'(go), 32'd1);
        wait_idle();

        send(0, 0, 0, 0);
        wait_idle();
        g0 = gos;
        send(0, 1, 4, 3);
        wait_idle();
`ifdef DRAW_SEQ_CLEAR_OLD_EN
        check("erase_gos", 32'(gos - g0), 32'd2);
`else
        check("erase_gos", 32'(gos - g0), 32'd1);
`endif

        g0 = gos;
        send(0, 0, 7, 0);
        check("bad_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("err_width", 32'(err), 32'd0);
        send(1, 0, 2, 6);
        repeat (6) @(posedge clk);
        #1;
        check("bad_busy2", 32'(busy), 32'd0);
        check("bad_no_go", 32'(gos - g0), 32'd0);

        hold = 1'b1;
        done = 1'b1;
        send(1, 0, 0, 0);
        repeat (6) @(posedge clk);
        #1;
        cnt = 0;
        last_acc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid  = 1'b1;
            req_kind   = 1'b1;
            req_player = i[0];
            req_col    = 3'(i);
            req_row    = 3'(i % 6);
            acc = req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                model_push(1, i % 2, i, i % 6);
                cnt++;
            end
            last_acc = acc;
        end
        req_valid = 1'b0;
        check("full_accepts", 32'(cnt), 32'd4);
        check("full_ready5", 32'(last_acc), 32'd0);
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1 done = 1'b1;
        hold = 1'b0;
        wait_idle();

        hold = 1'b1;
        send(1, 1, 5, 5);
        n = 0;
        while (!go && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_go_seen", 32'(go), 32'd1);
        done = 1'b0;
        send(1, 0, 1, 1);
        send(0, 0, 2, 0);
        check("mid_busy", 32'(busy), 32'd1);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_go", 32'(go), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        resetn = 1'b0;
        sb.delete();
        model_last = 0;
        done = 1'b1;
        hold = 1'b0;
        g0 = gos;
        repeat (30) @(posedge clk);
        #1;
        check("mid_no_go", 32'(gos - g0), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 7));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
